// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs load/store transactions on the
// data-memory port and produces a registered writeback bundle with lane select and extension.
module mem_stage #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [1:0]        mem_op_i,
    input  logic [2:0]        funct3_i,
    input  logic              rd_we_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [31:0]       rd_data_i,
    input  logic [31:0]       rs2_data_i,
    output logic              stall_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data,
    output logic              err_o
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t      state, state_next;

    logic        is_load, is_store, bad_f3, misaligned, accept_mem, reject_mem;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] load_shifted, load_data;

    logic        lat_store;
    logic        lat_wb_we;
    logic [4:0]  lat_rd_addr;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;

    always_comb begin
        is_load    = (mem_op_i == 2'b01);
        is_store   = (mem_op_i == 2'b10);
        bad_f3     = 1'b0;
        if (is_load)
            bad_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
        else if (is_store)
            bad_f3 = (funct3_i > 3'b010);
        misaligned = ((funct3_i[1:0] == 2'b01) && rd_data_i[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (rd_data_i[1:0] != 2'b00));
        accept_mem = valid_i && (is_load || is_store) && !bad_f3 && !misaligned;
        reject_mem = valid_i && (is_load || is_store) && (bad_f3 || misaligned);
    end

    // Store data is replicated across lanes so memory only needs the byte enables.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = rs2_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                store_be    = 4'b0001 << rd_data_i[1:0];
                store_wdata = {4{rs2_data_i[7:0]}};
            end
            2'b01: begin
                store_be    = 4'b0011 << rd_data_i[1:0];
                store_wdata = {2{rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Alignment is already guaranteed, so one shift serves both byte and halfword lanes.
    always_comb begin
        load_shifted = dmem_rdata >> {lat_off, 3'b000};
        case (lat_funct3)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_data = {24'b0, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_data = {16'b0, load_shifted[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mem) state_next = ACCESS;
            ACCESS:  if (dmem_ack)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stall_o = (state == ACCESS);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0;
            dmem_wdata  <= 32'b0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= 5'b0;
            wb_data     <= 32'b0;
            err_o       <= 1'b0;
            lat_store   <= 1'b0;
            lat_wb_we   <= 1'b0;
            lat_rd_addr <= 5'b0;
            lat_funct3  <= 3'b0;
            lat_off     <= 2'b0;
        end else begin
            wb_valid <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_mem) begin
                        dmem_req    <= 1'b1;
                        dmem_we     <= is_store;
                        dmem_addr   <= {rd_data_i[ADDR_W-1:2], 2'b00};
                        dmem_be     <= is_store ? store_be : 4'b0000;
                        dmem_wdata  <= is_store ? store_wdata : 32'b0;
                        lat_store   <= is_store;
                        lat_wb_we   <= rd_we_i && (rd_addr_i != 5'd0);
                        lat_rd_addr <= rd_addr_i;
                        lat_funct3  <= funct3_i;
                        lat_off     <= rd_data_i[1:0];
                    end else if (valid_i) begin
                        wb_valid <= 1'b1;
                        wb_addr  <= rd_addr_i;
                        wb_data  <= rd_data_i;
                        wb_we    <= reject_mem ? 1'b0 : (rd_we_i && (rd_addr_i != 5'd0));
                        err_o    <= reject_mem;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_addr  <= lat_rd_addr;
                        wb_we    <= lat_store ? 1'b0 : lat_wb_we;
                        wb_data  <= lat_store ? 32'b0 : load_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage in the 32-bit RISC-V integer pipeline. It handles loads, stores and ALU pass-through.
- Captures the execute result (rd_we/rd_addr/rd_data).
- For loads and stores, treats rd_data as the byte address and runs a req/ack transaction on the data-memory port, stalling upstream until it completes.
- Emits a registered writeback bundle with byte/halfword lane selection and sign/zero extension.

Parameters:
ADDR_W, 16, byte-address width presented on dmem_addr (low 2 bits always driven 0).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on the clock edge)
valid_i  input  1  execute-stage result valid this cycle
mem_op_i  input  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
funct3_i  input  3  load/store width: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_we_i  input  1  register write enable from execute
rd_addr_i  input  5  destination register
rd_data_i  input  32  ALU result; effective byte address for load/store
rs2_data_i  input  32  store data
stall_o  output  1  upstream must hold its outputs; combinational, =1 exactly when state==ACCESS
dmem_req  output  1  memory request, registered
dmem_we  output  1  1=write, 0=read
dmem_addr  output  ADDR_W  word-aligned byte address ({rd_data_i[ADDR_W-1:2],2'b00})
dmem_be  output  4  byte enables (writes only; 4'b0000 on reads)
dmem_wdata  output  32  lane-replicated store data
dmem_ack  input  1  memory completes the transaction this cycle; dmem_rdata valid when reading
dmem_rdata  input  32  read data
wb_valid  output  1  writeback bundle valid, one-cycle pulse
wb_we  output  1  register file write enable
wb_addr  output  5  writeback register
wb_data  output  32  writeback data
err_o  output  1  one-cycle pulse: misaligned address or illegal funct3; no memory access performed

Behaviour:
- States: IDLE, ACCESS. Inputs are sampled only in IDLE.
- Reset (rst=0 at edge): state=IDLE. dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_we, wb_addr, wb_data, err_o all 0.
- Reset while in ACCESS abandons the transaction: dmem_req=0 next cycle, and no writeback is produced for it.
- IDLE, valid_i=0: wb_valid=0, err_o=0 next cycle.
- IDLE, valid_i=1, mem_op none/reserved: next cycle wb_valid=1, wb_we=rd_we_i&&(rd_addr_i!=0), wb_addr=rd_addr_i, wb_data=rd_data_i. Latency 1; stay IDLE.
- IDLE, valid_i=1, load/store, misaligned or illegal funct3:
  - Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0.
  - Illegal: load funct3 011/110/111; store funct3 other than 000/001/010.
  - Next cycle: err_o=1, wb_valid=1, wb_we=0, wb_addr=rd_addr_i, wb_data=rd_data_i. Stay IDLE; dmem_req stays 0.
- IDLE, valid_i=1, legal load/store: next cycle state=ACCESS, with dmem_req=1, dmem_we, dmem_addr, dmem_be, dmem_wdata registered. Instruction context (rd_addr, funct3, addr[1:0], op) is latched.
- Store lane encoding:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<addr[1:0].
  - SW: wdata=rs2, be=4'b1111.
- ACCESS:
  - dmem_req and the other dmem_* outputs are held stable until dmem_ack=1 is sampled.
  - The cycle after ack: dmem_req=0, state=IDLE, wb_valid=1.
  - A new instruction may be accepted in that same IDLE cycle (back-to-back access gives req low for exactly 1 cycle).
  - dmem_ack while in IDLE is ignored.
- Load writeback:
  - Lane b=dmem_rdata[8*addr[1:0]+:8], lane h=dmem_rdata[16*addr[1]+:16].
  - LB sign-extends b; LBU zero-extends b; LH sign-extends h; LHU zero-extends h; LW passes the full word.
  - wb_we=latched rd_we&&(rd_addr!=0).
- Store writeback: wb_valid=1, wb_we=0, wb_data=0.
- Minimum load/store latency: accept at T, req at T+1, ack at T+1 gives wb_valid at T+2. No timeout; ack may take arbitrarily long.

Test Plan:
- ALU pass-through: valid_i=1, mem_op=00, rd_addr=5, rd_data=0x1234_5678, rd_we=1 -> next cycle wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x12345678; stall_o stays 0.
- LB sign-extend: addr=0x0103, funct3=000, ack after 3 cycles with rdata=0x80FF_0000 -> dmem_addr=0x0100, dmem_be=0, stall_o=1 for 3 cycles, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH upper half: addr=0x0042, rs2=0x0000_ABCD, ack same cycle as req -> dmem_we=1, be=4'b1100, wdata=0xABCDABCD; wb_valid=1 with wb_we=0 two cycles after accept.
- Misaligned LW: addr=0x0006 -> dmem_req never asserted, err_o=1 for one cycle, wb_we=0; illegal load funct3=011 -> same response.
- Reset mid-access: issue LW addr=0x10, hold ack=0, drive rst=0 for one edge -> dmem_req=0, state IDLE, no wb_valid; a subsequent ack=1 produces no output.
- Back-to-back: LW to rd_addr=0 with ack -> wb_we=0; immediately followed by SW -> dmem_req low for exactly 1 cycle between the two requests.
